// File: rtl/backbone_pkg.sv
// Shared fixed-point types for the backbone datapath.
// Operand, product and accumulator widths plus the saturating accumulate helper.
package backbone_pkg;

  localparam int DATA_W = 16;
  localparam int ACC_W  = 32;
  localparam int PROD_W = 2 * DATA_W;

  typedef logic signed [DATA_W-1:0] data_t;
  typedef logic signed [PROD_W-1:0] prod_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [ACC_W:0]    acc_wide_t;

  localparam acc_t ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam acc_t ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic [1:0] {
    ACC   = 2'd0,
    FLUSH = 2'd1,
    OUT   = 2'd2
  } mac_state_e;

  // One guard bit is enough: |prod| <= 2^(ACC_W-2) when ACC_W >= 2*DATA_W.
  function automatic acc_t sat_add_acc(
    input  acc_t  a,
    input  prod_t p,
    output logic  ovf
  );
    acc_wide_t sum;
    acc_t      res;
    sum = acc_wide_t'(a) + acc_wide_t'(p);
    ovf = 1'b0;
    if (sum > acc_wide_t'(ACC_MAX)) begin
      res = ACC_MAX;
      ovf = 1'b1;
    end else if (sum < acc_wide_t'(ACC_MIN)) begin
      res = ACC_MIN;
      ovf = 1'b1;
    end else begin
      res = sum[ACC_W-1:0];
    end
    return res;
  endfunction

endpackage

// File: rtl/mac_accum_stream.sv
// Streaming dot-product accumulator with saturating acc and
// a registered valid/ready result port, one result per vector.
module mac_accum_stream
  import backbone_pkg::*;
#(
  parameter int DATA_W  = backbone_pkg::DATA_W,
  parameter int ACC_W   = backbone_pkg::ACC_W,
  parameter int MAX_LEN = 1024,
  localparam int CNT_W  = $clog2(MAX_LEN + 1)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] in_a,
  input  logic signed [DATA_W-1:0] in_b,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  out_acc,
  output logic [CNT_W-1:0]         out_count,
  output logic                     out_ovf
);

  mac_state_e       state;
  prod_t            prod;
  logic             s1_valid;
  logic             s1_last;
  acc_t             acc;
  acc_t             acc_sum;
  logic             sum_ovf;
  logic             ovf;
  logic [CNT_W-1:0] count;
  logic             in_fire;
  logic             out_fire;

  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  always_comb begin
    sum_ovf = 1'b0;
    acc_sum = sat_add_acc(acc, prod, sum_ovf);
  end

  // S1: multiply stays inline for DSP mapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      s1_valid <= 1'b0;
      s1_last  <= 1'b0;
    end else begin
      s1_valid <= in_fire;
      s1_last  <= in_fire && in_last;
      if (in_fire) begin
        prod <= prod_t'(in_a) * prod_t'(in_b);
      end
    end
  end

  // S2 accumulate plus beat count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else if (out_fire) begin
      acc   <= '0;
      ovf   <= 1'b0;
      count <= '0;
    end else begin
      if (s1_valid) begin
        acc <= acc_sum;
        ovf <= ovf | sum_ovf;
      end
      if (in_fire && count != CNT_W'(MAX_LEN)) begin
        count <= count + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ACC;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      unique case (state)
        ACC: begin
          if (in_fire && in_last) begin
            state    <= FLUSH;
            in_ready <= 1'b0;
          end else begin
            in_ready <= 1'b1;
          end
        end
        FLUSH: begin
          state     <= OUT;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            state     <= ACC;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state     <= ACC;
          in_ready  <= 1'b0;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_acc   = acc;
  assign out_count = count;
  assign out_ovf   = ovf;

  logic unused;
  assign unused = s1_last;

endmodule

// File: tb/tb_mac_accum_stream.sv
// Directed bench for mac_accum_stream: hand-computed vectors,
// stall, saturation, gaps and mid-vector reset.
module tb_mac_accum_stream;

  logic               clk;
  logic               rst_n;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_a;
  logic signed [15:0] in_b;
  logic               in_last;
  logic               out_valid;
  logic               out_ready;
  logic signed [31:0] out_acc;
  logic [10:0]        out_count;
  logic               out_ovf;

  int checks = 0;
  int errors = 0;

  mac_accum_stream #(
    .DATA_W (16),
    .ACC_W  (32),
    .MAX_LEN(1024)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_acc  (out_acc),
    .out_count(out_count),
    .out_ovf  (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic signed [63:0] obs,
                     input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the transfer.
  task automatic send(input logic signed [15:0] a,
                      input logic signed [15:0] b,
                      input logic last);
    int k;
    k = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_last = last;
    while (!in_ready && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) chk("send_timeout", 1, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic recv(input string tag,
                      input logic signed [31:0] acc,
                      input int cnt,
                      input logic ovf);
    int k;
    k = 0;
    while (!out_valid && k < 50) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_valid"}, out_valid, 1);
    chk({tag, "_acc"}, out_acc, acc);
    chk({tag, "_count"}, out_count, cnt);
    chk({tag, "_ovf"}, out_ovf, ovf);
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk({tag, "_drop"}, out_valid, 0);
  endtask

  longint gold;
  logic   gold_ovf;
  logic signed [15:0] ra;
  logic signed [15:0] rb;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_acc", out_acc, 0);
    chk("rst_out_count", out_count, 0);
    chk("rst_out_ovf", out_ovf, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", in_ready, 1);

    // 1: 12 - 10 + 49 = 51, latency 2
    send(16'sd3, 16'sd4, 1'b0);
    send(-16'sd2, 16'sd5, 1'b0);
    send(16'sd7, 16'sd7, 1'b1);
    chk("t1_lat1", out_valid, 0);
    @(negedge clk);
    chk("t1_lat2", out_valid, 1);
    recv("t1", 32'sd51, 3, 1'b0);

    // 2: single beat, most negative squared
    send(-16'sd32768, -16'sd32768, 1'b1);
    recv("t2", 32'sd1073741824, 1, 1'b0);

    // 3: positive saturation, then clean vector
    send(16'sd32767, 16'sd32767, 1'b0);
    send(16'sd32767, 16'sd32767, 1'b0);
    send(16'sd32767, 16'sd32767, 1'b1);
    recv("t3", 32'sd2147483647, 3, 1'b1);
    send(16'sd1, 16'sd1, 1'b1);
    recv("t3b", 32'sd1, 1, 1'b0);

    // 4: output stall with pending input
    send(16'sd2, 16'sd3, 1'b1);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 16'sd5;
    in_b = 16'sd5;
    in_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_in_ready", in_ready, 0);
      chk("t4_valid", out_valid, 1);
      chk("t4_acc", out_acc, 6);
      chk("t4_count", out_count, 1);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("t4_hs_valid", out_valid, 0);
    chk("t4_hs_ready", in_ready, 1);
    chk("t4_hs_count", out_count, 0);
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
    recv("t4b", 32'sd25, 1, 1'b0);

    // 5: random operands with gaps, two back-to-back vectors
    for (int v = 0; v < 2; v++) begin
      gold = 0;
      gold_ovf = 1'b0;
      for (int i = 0; i < 8; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        ra = 16'($urandom);
        rb = 16'($urandom);
        gold = gold + longint'(ra) * longint'(rb);
        if (gold > 64'sd2147483647) begin
          gold = 64'sd2147483647;
          gold_ovf = 1'b1;
        end else if (gold < -64'sd2147483648) begin
          gold = -64'sd2147483648;
          gold_ovf = 1'b1;
        end
        send(ra, rb, i == 7);
      end
      recv("t5", 32'(gold), 8, gold_ovf);
    end

    // 6: reset mid-vector
    send(16'sd9, 16'sd9, 1'b0);
    send(16'sd4, 16'sd4, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", out_valid, 0);
    chk("t6_rst_ready", in_ready, 0);
    chk("t6_rst_acc", out_acc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(16'sd1, 16'sd2, 1'b1);
    recv("t6", 32'sd2, 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
